// File: rtl/np_action_pkg.sv
// np_action_pkg: shared action-table defaults and action word field layout
package np_action_pkg;
  localparam int ENTRIES_DEF    = 16;
  localparam int ACTION_W_DEF   = 64;
  localparam int TAG_W_DEF      = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CNT_W_DEF      = 32;
  localparam int ACT_OP_LSB     = 56;
  localparam int ACT_OP_W       = 8;
  localparam int ACT_ARG_LSB    = 0;
  localparam int ACT_ARG_W      = 56;
endpackage

// File: rtl/action_out_fifo.sv
// action_out_fifo: synchronous result FIFO with occupancy count
module action_out_fifo #(
  parameter int W = 73,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // storage, pointers and count; storage cleared so the head reads zero after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp <= nxt(wp);
      end
      if (pop) rp <= nxt(rp);
      count <= count + CW'(push) - CW'(pop);
    end
  assign rdata = mem[rp];
endmodule

// File: rtl/action_fetch.sv
// action_fetch: issues action-table reads for match results and returns actions in order
module action_fetch
  import np_action_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int ACTION_W = ACTION_W_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                match_valid,
  output logic                match_ready,
  input  logic                match_hit,
  input  logic [IDX_W-1:0]    match_idx,
  input  logic [TAG_W-1:0]    match_tag,
  output logic                mem_rd_en,
  output logic [IDX_W-1:0]    mem_rd_addr,
  input  logic [ACTION_W-1:0] mem_rd_data,
  input  logic [ACTION_W-1:0] cfg_default_action,
  output logic                act_valid,
  input  logic                act_ready,
  output logic [ACTION_W-1:0] act_data,
  output logic                act_hit,
  output logic [TAG_W-1:0]    act_tag,
  output logic [CNT_W-1:0]    stat_hit_cnt,
  output logic [CNT_W-1:0]    stat_miss_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = ACTION_W + 1 + TAG_W;
  logic acc, pop, inf_v, inf_hit;
  logic [TAG_W-1:0] inf_tag;
  logic [ACTION_W-1:0] inf_def;
  logic [CW-1:0] fifo_count;
  logic [CW:0] occ;
  logic [OW-1:0] head;
  assign occ = {1'b0, fifo_count} + (CW+1)'(inf_v);
  assign match_ready = rst_n && occ < (CW+1)'(FIFO_DEPTH);
  assign acc = match_valid && match_ready;
  assign mem_rd_en = acc && match_hit;
  assign mem_rd_addr = match_idx;
  assign act_valid = fifo_count != '0;
  assign pop = act_valid && act_ready;
  assign {act_data, act_hit, act_tag} = head;
  // in-flight slot: holds the accepted request while the memory read completes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inf_v <= 1'b0;
      inf_hit <= 1'b0;
      inf_tag <= '0;
      inf_def <= '0;
    end else begin
      inf_v <= acc;
      if (acc) begin
        inf_hit <= match_hit;
        inf_tag <= match_tag;
        inf_def <= cfg_default_action;
      end
    end
  // saturating hit/miss statistics
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_hit_cnt <= '0;
      stat_miss_cnt <= '0;
    end else if (acc) begin
      if (match_hit && !(&stat_hit_cnt)) stat_hit_cnt <= stat_hit_cnt + 1'b1;
      if (!match_hit && !(&stat_miss_cnt)) stat_miss_cnt <= stat_miss_cnt + 1'b1;
    end
  action_out_fifo #(.W(OW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(inf_v),
    .pop(pop),
    .wdata({inf_hit ? mem_rd_data : inf_def, inf_hit, inf_tag}),
    .rdata(head),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_action_fetch.sv
// tb_action_fetch: randomized check of action_fetch against a queue-based reference model
module tb_action_fetch;
  localparam int DEPTH = 4;
  localparam int CNT_W = 5;
  logic clk = 0, rst_n = 0;
  logic match_valid = 0, match_hit = 0, act_ready = 0;
  logic [3:0] match_idx = 0;
  logic [7:0] match_tag = 0;
  logic [63:0] cfg_default_action = 0, mem_rd_data = 0;
  logic match_ready, mem_rd_en, act_valid, act_hit;
  logic [3:0] mem_rd_addr;
  logic [63:0] act_data;
  logic [7:0] act_tag;
  logic [CNT_W-1:0] stat_hit_cnt, stat_miss_cnt;
  logic [63:0] mem [16];
  typedef struct {logic [63:0] data; logic hit; logic [7:0] tag; int cyc;} res_t;
  res_t q[$];
  int total = 0, bad = 0, cyc = 0, hc = 0, mc = 0;
  action_fetch #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .match_valid(match_valid), .match_ready(match_ready),
    .match_hit(match_hit), .match_idx(match_idx), .match_tag(match_tag),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .cfg_default_action(cfg_default_action), .act_valid(act_valid), .act_ready(act_ready),
    .act_data(act_data), .act_hit(act_hit), .act_tag(act_tag),
    .stat_hit_cnt(stat_hit_cnt), .stat_miss_cnt(stat_miss_cnt)
  );
  always #5 clk = ~clk;
  // action memory: synchronous read, data holds when not reading
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step(input logic v, input logic h, input logic [3:0] i, input logic [7:0] t,
                      input logic [63:0] d, input logic r);
    logic acc, ev;
    match_valid = v; match_hit = h; match_idx = i; match_tag = t;
    cfg_default_action = d; act_ready = r;
    @(negedge clk);
    chk("match_ready", match_ready, q.size() < DEPTH);
    acc = v && match_ready;
    chk("mem_rd_en", mem_rd_en, acc && h);
    if (acc && h) chk("mem_rd_addr", mem_rd_addr, i);
    ev = q.size() > 0 && q[0].cyc + 2 <= cyc;
    chk("act_valid", act_valid, ev);
    if (act_valid && ev) begin
      chk("act_data", act_data, q[0].data);
      chk("act_hit", act_hit, q[0].hit);
      chk("act_tag", act_tag, q[0].tag);
    end
    chk("hit_cnt", stat_hit_cnt, hc);
    chk("miss_cnt", stat_miss_cnt, mc);
    @(posedge clk);
    if (act_valid && r && q.size() > 0) void'(q.pop_front());
    if (acc) begin
      q.push_back('{data: h ? mem[i] : d, hit: h, tag: t, cyc: cyc});
      if (h) hc = hc < 2**CNT_W - 1 ? hc + 1 : hc;
      else mc = mc < 2**CNT_W - 1 ? mc + 1 : mc;
    end
    cyc++;
    #1;
  endtask
  task automatic rnd_step(input int rdy_pct);
    step($urandom_range(3) != 0, $urandom_range(1), 4'($urandom), 8'($urandom),
         {$urandom, $urandom}, $urandom_range(99) < rdy_pct);
  endtask
  initial begin
    for (int k = 0; k < 16; k++) mem[k] = {$urandom, $urandom};
    mem[5] = 64'hA5A5_0000_0000_0005;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", match_ready, 0);
    chk("rst_valid", act_valid, 0);
    chk("rst_data", act_data, 0);
    chk("rst_hitcnt", stat_hit_cnt, 0);
    rst_n = 1;
    step(1, 1, 5, 8'h11, 0, 1);
    step(1, 0, 0, 8'h22, 64'hDEAD, 1);
    step(0, 0, 0, 0, 64'hBEEF, 1);
    repeat (3) step(0, 0, 0, 0, 64'hBEEF, 1);
    for (int k = 0; k < 8; k++) step(1, 1, 4'(k), 8'(k), 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++) step(1, k[0], 4'(k + 8), 8'(8'h40 + k), 64'(k), 0);
    repeat (8) step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 400; k++) rnd_step(k < 200 ? 75 : 40);
    repeat (8) step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) step(1, 1, 4'(k + 2), 8'(8'h70 + k), 0, 0);
    match_valid = 1; match_hit = 1;
    rst_n = 0;
    #1;
    chk("arst_valid", act_valid, 0);
    chk("arst_ready", match_ready, 0);
    chk("arst_rd_en", mem_rd_en, 0);
    chk("arst_hitcnt", stat_hit_cnt, 0);
    chk("arst_misscnt", stat_miss_cnt, 0);
    q.delete();
    hc = 0; mc = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int k = 0; k < 300; k++) rnd_step(70);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
